mem_responder: RTL

//  Target side of memory_if: behavioural-synthesizable memory that answers driver_cb requests.

---
 rtl/mem_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Target-side memory endpoint: self-clearing storage, fixed-latency read pipeline, range error flags.
// Optional MEM_RESP_WR_BYPASS_EN: same-cycle write+read to one address returns the new data (write-first).
module mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  r_err,
  output logic                  w_err,
  output logic                  ready
);

  localparam int                ADDR_W     = $clog2(DEPTH);
  localparam logic [31:0]       DEPTH_W    = 32'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_W-1:0]       init_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]       index;
  logic                    in_range;
  logic                    do_write;
  logic                    do_read;
  logic [DATA_WIDTH-1:0]   rd_value;
  logic [RD_LATENCY-1:0]   pipe_valid;
  logic [RD_LATENCY-1:0]   pipe_err;
  logic [DATA_WIDTH-1:0]   pipe_data [RD_LATENCY];
  logic                    w_err_q;

  // The full 32-bit address takes part in the range check, so aliases never hit storage.
  assign in_range = (addr < DEPTH_W);
  assign index    = addr[ADDR_W-1:0];
  assign ready    = (state == RUN);
  assign do_write = ready && write_en && in_range;
  assign do_read  = ready && read_en;

  always_comb begin
    state_next = state;
    if (state == INIT && init_cnt == LAST_INDEX) begin
      state_next = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
      w_err_q  <= 1'b0;
    end else begin
      state   <= state_next;
      w_err_q <= ready && write_en && !in_range;
      if (state == INIT) begin
        init_cnt <= init_cnt + ADDR_W'(1);
      end
    end
  end

  // Storage is cleared only by the INIT sweep, never by reset directly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[init_cnt] <= '0;
      end else if (do_write) begin
        mem[index] <= w_data;
      end
    end
  end

  always_comb begin
    rd_value = '0;
    if (in_range) begin
`ifdef MEM_RESP_WR_BYPASS_EN
      if (do_write) begin
        rd_value = w_data;
      end else begin
        rd_value = mem[index];
      end
`else
      rd_value = mem[index];
`endif
    end
  end

  // Data and error stages load only behind a valid entry, so the last stage holds the previous response.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= do_read;
      if (do_read) begin
        pipe_data[0] <= rd_value;
        pipe_err[0]  <= !in_range;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
          pipe_err[i]  <= pipe_err[i-1];
        end
      end
    end
  end

  assign r_valid = pipe_valid[RD_LATENCY-1];
  assign r_err   = pipe_valid[RD_LATENCY-1] && pipe_err[RD_LATENCY-1];
  assign r_data  = pipe_data[RD_LATENCY-1];
  assign w_err   = w_err_q;

endmodule
